// File: rtl/score_counter_bcd_pkg.sv
// Shared types and seven-segment encoding for the BCD score counter.
// Segment codes are active-low, bit order gfedcba.
package score_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Codes A-F never come out of the counter; show them as a dark digit.
   function automatic logic [6:0] bcd_to_seg(input bcd_t d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/score_counter_bcd_digit.sv
// One decade of the score: counts 0..9 when enabled and all lower digits are 9.
module bcd_digit
   import score_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc,
   input  logic       carry_in,
   output logic [3:0] digit,
   output logic       is_nine
);

   bcd_t digit_reg;
   bcd_t digit_next;

   always_comb begin
      digit_next = digit_reg;
      if (clear) begin
         digit_next = 4'd0;
      end else if (inc && carry_in) begin
         digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         digit_reg <= 4'd0;
      end else begin
         digit_reg <= digit_next;
      end
   end

   assign digit   = digit_reg;
   assign is_nine = (digit_reg == 4'd9);

endmodule

// File: rtl/score_counter_bcd.sv
// Frog-game BCD score counter: divided sample tick, pass qualification, N-digit decimal score.
// Optional high-score register when SCORE_HISCORE_EN is defined.
module score_counter_bcd
   import score_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int TICK_DIV   = 128,
   parameter int OCC_W      = 8,
   parameter int WRAP       = 0
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    new_game,
   input  logic                    crash,
   input  logic [OCC_W-1:0]        occ,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic [7*NUM_DIGITS-1:0] seg,
   output logic                    overflow
`ifdef SCORE_HISCORE_EN
   ,
   output logic [4*NUM_DIGITS-1:0] hi_bcd,
   output logic [7*NUM_DIGITS-1:0] hi_seg
`endif
);

   localparam int CNT_W = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic SATURATE = (WRAP == 0);

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             tick_reg, tick_next;
   logic             pass_reg, pass_next;
   logic             overflow_reg, overflow_next;

   logic [NUM_DIGITS-1:0] nine_vec;
   logic [NUM_DIGITS:0]   carry;
   logic                  all_nine;
   logic                  inc;

   always_comb begin
      cnt_next  = cnt_reg + CNT_ONE;
      tick_next = 1'b0;
      if (cnt_reg == CNT_LAST) begin
         cnt_next  = '0;
         tick_next = 1'b1;
      end
   end

   assign pass_next = tick_reg & (|occ) & ~crash;

   // A saturating counter must not advance at all-9s, so the enable itself is gated.
   assign all_nine = carry[NUM_DIGITS];
   assign inc      = pass_reg & ~(SATURATE & all_nine);

   always_comb begin
      overflow_next = overflow_reg;
      if (new_game) begin
         overflow_next = 1'b0;
      end else if (pass_reg && all_nine) begin
         overflow_next = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_reg      <= '0;
         tick_reg     <= 1'b0;
         pass_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         cnt_reg      <= cnt_next;
         tick_reg     <= tick_next;
         pass_reg     <= pass_next;
         overflow_reg <= overflow_next;
      end
   end

   assign carry[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         bcd_digit u_digit (
            .clock    (clock),
            .reset    (reset),
            .clear    (new_game),
            .inc      (inc),
            .carry_in (carry[gi]),
            .digit    (bcd[4*gi +: 4]),
            .is_nine  (nine_vec[gi])
         );
         assign carry[gi+1]     = carry[gi] & nine_vec[gi];
         assign seg[7*gi +: 7]  = bcd_to_seg(bcd[4*gi +: 4]);
      end
   endgenerate

   assign overflow = overflow_reg;

`ifdef SCORE_HISCORE_EN
   logic [4*NUM_DIGITS-1:0] hi_bcd_reg, hi_bcd_next;

   // Packed BCD orders the same as its decimal value, so a plain compare suffices.
   assign hi_bcd_next = (bcd > hi_bcd_reg) ? bcd : hi_bcd_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         hi_bcd_reg <= '0;
      end else begin
         hi_bcd_reg <= hi_bcd_next;
      end
   end

   assign hi_bcd = hi_bcd_reg;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_hi_seg
         assign hi_seg[7*gi +: 7] = bcd_to_seg(hi_bcd_reg[4*gi +: 4]);
      end
   endgenerate
`endif

endmodule

// File: tb/tb_score_counter_bcd.sv
// Bench for score_counter_bcd: three instances (3-digit saturating, 2-digit saturating,
// 2-digit wrapping) share stimulus; an integer-score model checks every cycle.
module tb_score_counter_bcd;

   localparam int TD = 3;

   logic       clock = 1'b0;
   logic       reset, new_game, crash;
   logic [7:0] occ;

   logic [11:0] bcd_a;  logic [20:0] seg_a;  logic ovf_a;
   logic [7:0]  bcd_b;  logic [13:0] seg_b;  logic ovf_b;
   logic [7:0]  bcd_c;  logic [13:0] seg_c;  logic ovf_c;
`ifdef SCORE_HISCORE_EN
   logic [11:0] hi_bcd_a; logic [20:0] hi_seg_a;
   logic [7:0]  hi_bcd_b; logic [13:0] hi_seg_b;
   logic [7:0]  hi_bcd_c; logic [13:0] hi_seg_c;
`endif

   always #5 clock = ~clock;

   score_counter_bcd #(.NUM_DIGITS(3), .TICK_DIV(TD), .OCC_W(8), .WRAP(0)) dut_a (
      .clock(clock), .reset(reset), .new_game(new_game), .crash(crash), .occ(occ),
      .bcd(bcd_a), .seg(seg_a), .overflow(ovf_a)
`ifdef SCORE_HISCORE_EN
      , .hi_bcd(hi_bcd_a), .hi_seg(hi_seg_a)
`endif
   );

   score_counter_bcd #(.NUM_DIGITS(2), .TICK_DIV(TD), .OCC_W(8), .WRAP(0)) dut_b (
      .clock(clock), .reset(reset), .new_game(new_game), .crash(crash), .occ(occ),
      .bcd(bcd_b), .seg(seg_b), .overflow(ovf_b)
`ifdef SCORE_HISCORE_EN
      , .hi_bcd(hi_bcd_b), .hi_seg(hi_seg_b)
`endif
   );

   score_counter_bcd #(.NUM_DIGITS(2), .TICK_DIV(TD), .OCC_W(8), .WRAP(1)) dut_c (
      .clock(clock), .reset(reset), .new_game(new_game), .crash(crash), .occ(occ),
      .bcd(bcd_c), .seg(seg_c), .overflow(ovf_c)
`ifdef SCORE_HISCORE_EN
      , .hi_bcd(hi_bcd_c), .hi_seg(hi_seg_c)
`endif
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nd_of(input int k);
      return (k == 0) ? 3 : 2;
   endfunction

   function automatic bit wraps(input int k);
      return (k == 2);
   endfunction

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r = '0;
      int t = v;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [31:0] exp_seg(input int v, input int nd);
      logic [31:0] r = '0;
      int t = v;
      for (int i = 0; i < nd; i++) begin
         r[7*i +: 7] = seg_of(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Reference model: scores kept as plain integers, timing from edges since reset.
   int n_edge;
   bit m_tick, m_pend;
   int m_score [3];
   bit m_ovf   [3];
   int m_hi    [3];

   always @(posedge clock) begin
      if (reset) begin
         n_edge = 0; m_tick = 0; m_pend = 0;
         for (int k = 0; k < 3; k++) begin
            m_score[k] = 0; m_ovf[k] = 0; m_hi[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (m_score[k] > m_hi[k]) m_hi[k] = m_score[k];
            if (new_game) begin
               m_score[k] = 0; m_ovf[k] = 0;
            end else if (m_pend) begin
               if (m_score[k] == pow10(nd_of(k)) - 1) begin
                  m_ovf[k] = 1;
                  if (wraps(k)) m_score[k] = 0;
               end else begin
                  m_score[k] = m_score[k] + 1;
               end
            end
         end
         m_pend = m_tick && (occ != 8'h00) && !crash;
         n_edge = n_edge + 1;
         m_tick = (n_edge % (TD + 1)) == 0;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("a_bcd", 32'(bcd_a), to_bcd(m_score[0]));
         check("a_seg", 32'(seg_a), exp_seg(m_score[0], 3));
         check("a_ovf", 32'(ovf_a), 32'(m_ovf[0]));
         check("b_bcd", 32'(bcd_b), to_bcd(m_score[1]));
         check("b_seg", 32'(seg_b), exp_seg(m_score[1], 2));
         check("b_ovf", 32'(ovf_b), 32'(m_ovf[1]));
         check("c_bcd", 32'(bcd_c), to_bcd(m_score[2]));
         check("c_seg", 32'(seg_c), exp_seg(m_score[2], 2));
         check("c_ovf", 32'(ovf_c), 32'(m_ovf[2]));
`ifdef SCORE_HISCORE_EN
         check("a_hi", 32'(hi_bcd_a), to_bcd(m_hi[0]));
         check("a_hiseg", 32'(hi_seg_a), exp_seg(m_hi[0], 3));
         check("b_hi", 32'(hi_bcd_b), to_bcd(m_hi[1]));
         check("c_hi", 32'(hi_bcd_c), to_bcd(m_hi[2]));
`endif
      end
   end

   // One tick period, starting two cycles before the tick; cmode 1 = crash held, 2 = crash off-tick only.
   task automatic window(input logic [7:0] o, input int cmode, input bit ng);
      for (int i = 0; i < TD + 1; i++) begin
         occ      = o;
         crash    = (cmode == 1) || (cmode == 2 && i != 2);
         new_game = ng && (i == 3);
         @(negedge clock);
      end
      crash = 1'b0; new_game = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  occ;
      int          cmode;
      logic [11:0] exp;
   } vec_t;

   vec_t tab [8];

   initial begin
      tab[0] = '{8'h01, 0, 12'h011};
      tab[1] = '{8'h00, 0, 12'h011};
      tab[2] = '{8'h80, 1, 12'h011};
      tab[3] = '{8'h80, 2, 12'h012};
      tab[4] = '{8'hFF, 0, 12'h013};
      tab[5] = '{8'h00, 2, 12'h013};
      tab[6] = '{8'h10, 1, 12'h013};
      tab[7] = '{8'h02, 2, 12'h014};

      reset = 1'b1; new_game = 1'b0; crash = 1'b0; occ = 8'h00;
      @(negedge clock);
      chk_en = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_bcd", 32'(bcd_a), 32'h000);
      check("rst_seg", 32'(seg_a), 32'(21'b1000000_1000000_1000000));

      // Idle lanes: nothing scores.
      reset = 1'b0;
      repeat (5 * (TD + 1)) @(negedge clock);
      check("idle_bcd", 32'(bcd_a), 32'h000);
      check("idle_seg0", 32'(seg_a[6:0]), 32'(7'b1000000));
      check("idle_ovf", 32'(ovf_a), 32'h0);

      // First tick in clock 4, first point visible after clock 6.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; occ = 8'h01;
      repeat (5) @(negedge clock);
      check("first_pre", 32'(bcd_a), 32'h000);
      @(negedge clock);
      check("first_pt", 32'(bcd_a), 32'h001);
      repeat (36) @(negedge clock);
      check("ten_bcd", 32'(bcd_a), 32'h010);
      check("ten_seg", 32'(seg_a), 32'(21'b1000000_1111001_1000000));

      for (int v = 0; v < 8; v++) begin
         window(tab[v].occ, tab[v].cmode, 1'b0);
         check($sformatf("tab%0d", v), 32'(bcd_a), 32'(tab[v].exp));
      end

      // new_game on the pass cycle at 42.
      repeat (28) window(8'h01, 0, 1'b0);
      check("pre42", 32'(bcd_a), 32'h042);
      window(8'h01, 0, 1'b1);
      check("ng_bcd", 32'(bcd_a), 32'h000);
      check("ng_ovf", 32'(ovf_a), 32'h0);
`ifdef SCORE_HISCORE_EN
      check("ng_hi", 32'(hi_bcd_a), 32'h042);
`endif

      // Two-digit end of range: saturate versus wrap, overflow sticky.
      repeat (99) window(8'h04, 0, 1'b0);
      check("b99", 32'(bcd_b), 32'h99);
      check("c99", 32'(bcd_c), 32'h99);
      check("b99_ovf", 32'(ovf_b), 32'h0);
      window(8'h04, 0, 1'b0);
      check("b_sat", 32'(bcd_b), 32'h99);
      check("b_sat_ovf", 32'(ovf_b), 32'h1);
      check("c_wrap", 32'(bcd_c), 32'h00);
      check("c_wrap_ovf", 32'(ovf_c), 32'h1);
      check("a_100", 32'(bcd_a), 32'h100);
      window(8'h04, 0, 1'b0);
      check("c_sticky", 32'(bcd_c), 32'h01);
      check("c_sticky_ovf", 32'(ovf_c), 32'h1);

      // Reset mid-count at 7, then divider restarts from phase zero.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; occ = 8'h00;
      repeat (2) @(negedge clock);
      repeat (7) window(8'h01, 0, 1'b0);
      check("at7", 32'(bcd_a), 32'h007);
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_bcd", 32'(bcd_a), 32'h000);
      check("mid_rst_seg", 32'(seg_a), 32'(21'b1000000_1000000_1000000));
      check("mid_rst_ovf", 32'(ovf_c), 32'h0);
      reset = 1'b0; occ = 8'h01;
      repeat (5) @(negedge clock);
      check("rst_phase_pre", 32'(bcd_a), 32'h000);
      @(negedge clock);
      check("rst_phase_pt", 32'(bcd_a), 32'h001);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         occ      = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         crash    = ($urandom_range(0, 3) == 0);
         new_game = ($urandom_range(0, 199) == 0);
         reset    = ($urandom_range(0, 999) == 0);
         @(negedge clock);
      end
      reset = 1'b0; new_game = 1'b0; crash = 1'b0; occ = 8'h00;
      @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_counter_bcd.md
# score_counter_bcd

Parametrised multi-digit BCD score counter for the frog game. It samples lane occupancy on a slow divided tick and qualifies each sample as a "pass" when no crash is present. Each pass increments an N-digit decimal score with ripple carry. Digits are driven to the HEX displays as active-low seven-segment codes, replacing the per-digit hand-coded state machines.

## Interface
Parameters:
- NUM_DIGITS, 3, number of BCD digits (1..6)
- TICK_DIV, 128, sample divider; one sample tick every TICK_DIV+1 clocks (>=1)
- OCC_W, 8, width of lane-occupancy input
- WRAP, 0, 0 = saturate at all-9s; 1 = wrap to all-0s

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- new_game  in  1  synchronous clear of score/overflow only (hi-score kept)
- crash  in  1  frog collision; blocks pass qualification
- occ  in  OCC_W  lane occupancy; any nonzero bit = frog crossing
- bcd  out  4*NUM_DIGITS  score, digit i at [4i+3:4i], digit 0 = units
- seg  out  7*NUM_DIGITS  active-low gfedcba of digit i at [7i+6:7i]
- overflow  out  1  sticky; set on increment from all-9s
- hi_bcd / hi_seg  out  4*NUM_DIGITS / 7*NUM_DIGITS  high score (SCORE_HISCORE_EN only)

## Operation
- Divider: counter 0..TICK_DIV; at TICK_DIV, next cycle counter=0 and tick=1; otherwise tick=0, counter+1.
- Pass register: pass <= tick & (occ != 0) & ~crash. Registered, one cycle.
- Increment when pass=1: digit 0 +1; digit i increments only when digits 0..i-1 all equal 9; digit 9 rolls to 0.
- All digits 9 and pass: WRAP=0 -> score holds at all-9s, overflow<=1; WRAP=1 -> score to all-0s, overflow<=1.
- overflow is sticky until reset or new_game.
- new_game and pass in the same cycle: new_game wins; score=0, increment lost.
- Segment codes 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Illegal BCD (A-F) displays 1111111 (blank) and is never produced by the counter.
- seg is combinational from bcd.

## Timing
- Reset values: counter=0, tick=0, pass=0, bcd=0, seg = 1000000 per digit, overflow=0, hi_bcd=0.
- First tick is high in clock TICK_DIV+1 after reset deassertion, and then every TICK_DIV+1 clocks.
- Latency: occ/crash sampled on tick cycle -> pass next cycle -> bcd/seg updated the following cycle (2 clocks from tick).
- crash or occ changes outside the tick cycle have no effect.
- reset mid-operation: all state is cleared at that edge, including divider phase.

## Configuration
- SCORE_HISCORE_EN defined: hi_bcd register; each cycle, if bcd > hi_bcd (unsigned compare, valid for BCD), hi_bcd <= bcd. hi_bcd is cleared by reset only, not by new_game. hi_seg is decoded from hi_bcd. Update lags score by one cycle.
- Not defined: hi_bcd/hi_seg ports and logic absent; all other behaviour identical.

## Structure
- Package score_pkg:
  - typedef bcd_t (logic [3:0])
  - seven-segment constants SEG_0..SEG_9, SEG_BLANK
  - function bcd_to_seg
- Sub-module bcd_digit:
  - ports: clock, reset, clear, inc, carry_in; outputs digit, is_nine
  - instantiated NUM_DIGITS times via generate; carry chain is the AND of lower is_nine flags.

## Test plan
- Reset, occ=0 for 5*(TICK_DIV+1) clocks -> bcd=0, seg digit0=1000000, overflow=0.
- TICK_DIV=3, occ=8'h01, crash=0 -> first tick at clock 4, bcd=1 at clock 6; after 10 ticks bcd=010, seg digit1=1111001.
- crash=1 held across a tick, occ nonzero -> bcd unchanged; crash raised only off-tick -> increments normally.
- NUM_DIGITS=2, preload to 99 via passes -> WRAP=0: stays 99, overflow=1; WRAP=1: 00, overflow=1.
- new_game asserted on the pass cycle at score 42 -> score 00, overflow 0; with SCORE_HISCORE_EN, hi_bcd stays 42.
- reset asserted mid-count at score 7 -> all outputs at reset values next cycle; next tick TICK_DIV+1 clocks later.
